mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_pkg.sv | 8 +
 rtl/mem_align.sv | 27 ++
 rtl/mem_access.sv | 70 +++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM states, access size codes and control-field positions for the MEM stage.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
  localparam int MC_SIZE_LO = 0;
  localparam int MC_SIZE_HI = 1;
  localparam int MC_ZEXT    = 2;
endpackage

// File: rtl/mem_align.sv
// mem_align: byte-lane strobes, store replication and load lane extraction/extension.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        zext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata_i[{addr_lo_i, 3'b000} +: 8];
    h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wstrb_o = size_i == SZ_BYTE ? 4'b0001 << addr_lo_i :
              size_i == SZ_HALF ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) :
              size_i == SZ_WORD ? 4'b1111 : 4'b0000;
    wdata_o = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
              size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    ldata_o = size_i == SZ_BYTE ? {{24{~zext_i & b[7]}}, b} :
              size_i == SZ_HALF ? {{16{~zext_i & h[15]}}, h} : rdata_i;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage data-bus sequencer; stalls the pipeline until a load/store completes.
module mem_access
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_write_mem,
  input  logic        i_write_regfile,
  input  logic        i_mem_to_regfile,
  input  logic [31:0] i_da,
  input  logic [31:0] i_db,
  input  logic [4:0]  i_rn,
  input  logic [7:0]  i_mem_control,
  output logic        o_stall_req,
  output logic        d_req,
  output logic        d_wr,
  output logic [31:0] d_addr,
  output logic [3:0]  d_wstrb,
  output logic [31:0] d_wdata,
  input  logic        d_addr_ok,
  input  logic        d_data_ok,
  input  logic [31:0] d_rdata,
  output logic        o_write_regfile,
  output logic [4:0]  o_rn,
  output logic [31:0] o_wdata,
  output logic        o_addr_err
);
  state_e      state_q, state_d;
  logic [31:0] load_q, load_d;
  logic [1:0]  size;
  logic        mem_op, misaligned, aligned_op;
  logic [3:0]  strb;
  logic [31:0] ldata;
  logic        unused_mc;
  assign size      = i_mem_control[MC_SIZE_HI:MC_SIZE_LO];
  assign unused_mc = ^i_mem_control[7:3];
  mem_align u_align (
    .size_i    (size),
    .addr_lo_i (i_da[1:0]),
    .zext_i    (i_mem_control[MC_ZEXT]),
    .wdata_i   (i_db),
    .rdata_i   (d_rdata),
    .wstrb_o   (strb),
    .wdata_o   (d_wdata),
    .ldata_o   (ldata)
  );
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
    load_q  <= reset ? '0 : load_d;
  end
  always_comb begin
    mem_op     = (i_write_mem | i_mem_to_regfile) & (size != SZ_RSVD);
    misaligned = mem_op & (((size == SZ_HALF) & i_da[0]) | ((size == SZ_WORD) & (i_da[1:0] != 2'b00)));
    aligned_op = mem_op & ~misaligned;
    state_d = state_q == IDLE ? (aligned_op ? REQ : IDLE) :
              state_q == REQ  ? (d_addr_ok ? WAIT : REQ) :
              state_q == WAIT ? (d_data_ok ? DONE : WAIT) : IDLE;
    load_d = (state_q == WAIT && d_data_ok && i_mem_to_regfile) ? ldata : load_q;
    o_addr_err  = ~reset & misaligned;
    d_req       = ~reset & (state_q == REQ);
    d_wr        = d_req & i_write_mem;
    d_wstrb     = d_wr ? strb : 4'b0000;
    d_addr      = {i_da[31:2], 2'b00};
    o_stall_req = ~reset & ((state_q == REQ) | (state_q == WAIT) | ((state_q == IDLE) & aligned_op));
    // loads only write back once the captured data is presented in DONE
    o_write_regfile = ~reset & i_write_regfile & (i_mem_to_regfile ? (state_q == DONE) : ~misaligned);
    o_rn    = i_rn;
    o_wdata = (state_q == DONE && i_mem_to_regfile) ? load_q : i_da;
  end
endmodule
